// File: rtl/inst_buf_pkg.sv
// rtl/inst_buf_pkg.sv - shared widths and constants for the fetch-to-decode instruction buffer
package inst_buf_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/inst_buf_fifo.sv
// rtl/inst_buf_fifo.sv - DEPTH-entry pc/inst storage with wrapping pointers and occupancy count
module inst_buf_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_pc,
  input  logic [INST_W-1:0] wr_inst,
  input  logic              rd_en,
  output logic [ADDR_W-1:0] rd_pc,
  output logic [INST_W-1:0] rd_inst,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign rd_pc   = pc_mem_q[rd_ptr_q];
  assign rd_inst = inst_mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; entries outside the count are ignored.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem_q[wr_ptr_q]   <= wr_pc;
      inst_mem_q[wr_ptr_q] <= wr_inst;
    end
  end

endmodule

// File: rtl/inst_buf.sv
// rtl/inst_buf.sv - fetch-to-decode instruction buffer with registered ID output
// INST_BUF_BYPASS_EN: when defined, a push into an empty buffer goes straight to the output register
module inst_buf
  import inst_buf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = InstAddrBus,
  parameter int INST_W = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push_valid,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [INST_W-1:0] push_inst,
  output logic              push_ready,
  input  logic              id_stall,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst
);

  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_wr;
  logic              fifo_rd;
  logic [ADDR_W-1:0] head_pc;
  logic [INST_W-1:0] head_inst;
  logic              accept;
  logic              advance;

  logic              id_valid_q, id_valid_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;

  // No full pass-through: a pop in the same cycle does not open a slot.
  assign push_ready = !fifo_full && !flush;
  assign accept     = push_valid && push_ready;
  assign advance    = !id_stall || !id_valid_q;
  assign fifo_rd    = advance && !fifo_empty && !flush;

`ifdef INST_BUF_BYPASS_EN
  logic bypass;
  assign bypass  = advance && fifo_empty && accept;
  assign fifo_wr = accept && !bypass;
`else
  assign fifo_wr = accept;
`endif

  inst_buf_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (fifo_wr),
    .wr_pc   (push_pc),
    .wr_inst (push_inst),
    .rd_en   (fifo_rd),
    .rd_pc   (head_pc),
    .rd_inst (head_inst),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    if (flush) begin
      id_valid_d = 1'b0;
      id_pc_d    = ADDR_W'(ZeroWord);
      id_inst_d  = INST_W'(ZeroWord);
    end else if (advance) begin
      if (!fifo_empty) begin
        id_valid_d = 1'b1;
        id_pc_d    = head_pc;
        id_inst_d  = head_inst;
      end
`ifdef INST_BUF_BYPASS_EN
      else if (bypass) begin
        id_valid_d = 1'b1;
        id_pc_d    = push_pc;
        id_inst_d  = push_inst;
      end
`endif
      else begin
        id_valid_d = 1'b0;
        id_pc_d    = ADDR_W'(ZeroWord);
        id_inst_d  = INST_W'(ZeroWord);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= ADDR_W'(ZeroWord);
      id_inst_q  <= INST_W'(ZeroWord);
    end else begin
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;

endmodule

// File: tb/tb_inst_buf.sv
// tb/tb_inst_buf.sv - self-checking bench for inst_buf against a queue-based reference model
module tb_inst_buf;

  localparam int DEPTH = 4;
`ifdef INST_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, push_valid, id_stall;
  logic [31:0] push_pc, push_inst;
  logic        push_ready, id_valid;
  logic [31:0] id_pc, id_inst;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq_pc[$];
  logic [31:0] mq_inst[$];
  logic        m_v    = 1'b0;
  logic [31:0] m_pc   = '0;
  logic [31:0] m_inst = '0;

  inst_buf #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_pc    (push_pc),
    .push_inst  (push_inst),
    .push_ready (push_ready),
    .id_stall   (id_stall),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_inst    (id_inst)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic f, input logic pv,
                       input logic [31:0] pc, input logic [31:0] ins, input logic st);
    rst = r; flush = f; push_valid = pv; push_pc = pc; push_inst = ins; id_stall = st;
    #1;
  endtask

  // Reference: a plain queue plus one output slot, advanced per clock edge.
  task automatic tick();
    bit acc, adv;
    acc = push_valid && !flush && (mq_pc.size() < DEPTH);
    adv = !id_stall || !m_v;
    @(posedge clk);
    if (rst || flush) begin
      mq_pc.delete(); mq_inst.delete();
      m_v = 1'b0; m_pc = '0; m_inst = '0;
    end else begin
      if (adv) begin
        if (mq_pc.size() > 0) begin
          m_v = 1'b1; m_pc = mq_pc.pop_front(); m_inst = mq_inst.pop_front();
        end else if (BYP && acc) begin
          m_v = 1'b1; m_pc = push_pc; m_inst = push_inst; acc = 1'b0;
        end else begin
          m_v = 1'b0; m_pc = '0; m_inst = '0;
        end
      end
      if (acc) begin
        mq_pc.push_back(push_pc); mq_inst.push_back(push_inst);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0); tick(); tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", id_valid); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", id_pc); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", id_inst); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", push_ready); end
  endtask

  task automatic test_latency();
    drive(0, 0, 1, 32'h100, 32'h0000_0013, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    if (!BYP) tick();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got %b want 1", id_valid); end
    checks++; if (id_pc !== 32'h100) begin errors++; $display("FAIL latency_pc got %h want 100", id_pc); end
    checks++; if (id_inst !== 32'h13) begin errors++; $display("FAIL latency_inst got %h want 13", id_inst); end
    tick(); tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL latency_bubble got %b want 0", id_valid); end
  endtask

  task automatic test_fill_stall();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 1);
      checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got %b want 1", i, push_ready); end
      tick();
    end
    drive(0, 0, 1, 32'h114, 32'hA005, 1);
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", push_ready); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin
      errors++; $display("FAIL stall_hold got %b/%h want 1/100", id_valid, id_pc); end
  endtask

  task automatic test_drain_full();
    drive(0, 0, 1, 32'h114, 32'hA005, 0);
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL pop_cycle_ready got %b want 0", push_ready); end
    tick();
    for (int i = 1; i <= 4; i++) begin
      checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 + 32'(4 * i) || id_inst !== 32'hA000 + 32'(i)) begin
        errors++; $display("FAIL drain%0d got %b/%h/%h want 1/%h/%h", i, id_valid, id_pc, id_inst,
                           32'h100 + 32'(4 * i), 32'hA000 + 32'(i)); end
      drive(0, 0, 0, 0, 0, 0); tick();
    end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL drain_end got %b want 0", id_valid); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 32'h300 + 32'(4 * i), $urandom, 1); tick();
    end
    drive(0, 1, 1, 32'h400, 32'hDEAD, 1);
    checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", push_ready); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0) begin
      errors++; $display("FAIL flush_out got %b/%h/%h want 0/0/0", id_valid, id_pc, id_inst); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL flush_empty got %b want 1", push_ready); end
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_lost got %b want 0", id_valid); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_inst[6];
    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];
    for (int c = 0; c < 14; c++) begin
      if (c < 6) begin
        exp_inst[c] = $urandom;
        drive(0, 0, 1, 32'h200 + 32'(4 * c), exp_inst[c], 0);
      end else begin
        drive(0, 0, 0, 0, 0, 0);
      end
      tick();
      if (id_valid === 1'b1) begin got_pc.push_back(id_pc); got_inst.push_back(id_inst); end
    end
    checks++; if (got_pc.size() != 6) begin errors++; $display("FAIL wrap_count got %0d want 6", got_pc.size()); end
    for (int i = 0; i < 6 && i < got_pc.size(); i++) begin
      checks++; if (got_pc[i] !== 32'h200 + 32'(4 * i) || got_inst[i] !== exp_inst[i]) begin
        errors++; $display("FAIL wrap%0d got %h/%h want %h/%h", i, got_pc[i], got_inst[i],
                           32'h200 + 32'(4 * i), exp_inst[i]); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 32'h500 + 32'(4 * i), $urandom, 1); tick();
    end
    drive(1, 0, 1, 32'h600, 32'h1, 1); tick();
    drive(0, 0, 0, 0, 0, 1);
    checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0) begin
      errors++; $display("FAIL midrst_out got %b/%h/%h want 0/0/0", id_valid, id_pc, id_inst); end
    checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", push_ready); end
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL midrst_gone got %b want 0", id_valid); end
  endtask

  task automatic test_random();
    logic exp_ready;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(49) == 0, $urandom_range(15) == 0, $urandom_range(9) < 6,
            $urandom, $urandom, $urandom_range(9) < 4);
      exp_ready = !flush && (mq_pc.size() < DEPTH);
      checks++; if (push_ready !== exp_ready) begin
        errors++; $display("FAIL rnd_ready c%0d got %b want %b", c, push_ready, exp_ready); end
      tick();
      checks++; if (id_valid !== m_v || id_pc !== m_pc || id_inst !== m_inst) begin
        errors++; $display("FAIL rnd_out c%0d got %b/%h/%h want %b/%h/%h", c, id_valid, id_pc, id_inst,
                           m_v, m_pc, m_inst); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill_stall();
    test_drain_full();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
